// File: rtl/message_loader.sv
// rtl/message_loader.sv - scrolling-text message memory, writer side with commit lock
//
// Purpose:
//   Accepts character codes over a valid/ready handshake into a DEPTH x DW
//   register file, locks the message on commit, and exposes a zero-latency
//   combinational read port for the LED display driver. A clear pulse blanks
//   the memory one entry per cycle and restarts loading.
//
// Optional feature (macro MSG_FILL_EN):
//   When defined, a commit of L characters (0 < L < DEPTH) first replicates
//   the message across the unused entries (mem[i] = char[i mod L]) so the
//   scroll wraps seamlessly, then locks. When undefined, commit locks
//   immediately and unused entries stay blank.
//
// Ports:
//   clk         in   1     system clock, all state on rising edge
//   reset       in   1     asynchronous, active-high
//   char_in     in   DW    character code to store
//   char_valid  in   1     char_in valid this cycle
//   char_ready  out  1     loader can accept a character
//   commit      in   1     one-cycle pulse: lock current message
//   clear       in   1     one-cycle pulse: erase message, restart
//   busy        out  1     clear or fill sequence in progress
//   msg_valid   out  1     message locked and ready for display
//   msg_len     out  AW+1  number of characters stored (0..DEPTH)
//   rd_addr     in   AW    display read address
//   rd_data     out  DW    mem[rd_addr], combinational

module message_loader #(
  parameter int            DEPTH      = 16,
  parameter int            AW         = 4,
  parameter int            DW         = 4,
  parameter logic [DW-1:0] BLANK_CHAR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] char_in,
  input  logic          char_valid,
  output logic          char_ready,
  input  logic          commit,
  input  logic          clear,
  output logic          busy,
  output logic          msg_valid,
  output logic [AW:0]   msg_len,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd3;
`ifdef MSG_FILL_EN
  localparam logic [1:0] S_FILL   = 2'd2;
`endif

  localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH-1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] idx_q, idx_d;      // sweep index shared by CLEAR and FILL
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          accept;
  logic [AW:0]   len_acc;           // length including a same-cycle accept
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  assign char_ready = (state_q == S_LOAD) && (len_q != LEN_FULL);
  // clear outranks a character offered in the same cycle
  assign accept     = char_ready && char_valid && !clear;
  assign len_acc    = len_q + {{AW{1'b0}}, accept};

`ifdef MSG_FILL_EN
  assign busy       = (state_q == S_CLEAR) || (state_q == S_FILL);
`else
  assign busy       = (state_q == S_CLEAR);
`endif
  assign msg_valid  = (state_q == S_LOCKED);
  assign msg_len    = len_q;
  assign rd_data    = mem_q[rd_addr];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    len_d    = len_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    wdata    = char_in;

    if (clear) begin
      // Accepted in every state; a clear mid-sweep restarts from entry 0.
      state_d  = S_CLEAR;
      idx_d    = '0;
      wr_ptr_d = '0;
      len_d    = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            len_d    = len_acc;
          end
          if (commit && (len_acc != '0)) begin
`ifdef MSG_FILL_EN
            if (len_acc == LEN_FULL) begin
              state_d = S_LOCKED;
            end else begin
              state_d = S_FILL;
              idx_d   = len_acc[AW-1:0];
            end
`else
            state_d = S_LOCKED;
`endif
          end
        end
        S_CLEAR: begin
          we    = 1'b1;
          waddr = idx_q;
          wdata = BLANK_CHAR;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_LOAD;
          end
        end
`ifdef MSG_FILL_EN
        S_FILL: begin
          // Source entry i-L was either loaded or filled on an earlier cycle,
          // so copying forward yields mem[i] = char[i mod L].
          we    = 1'b1;
          waddr = idx_q;
          wdata = mem_q[idx_q - len_q[AW-1:0]];
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_LOCKED;
          end
        end
`endif
        default: begin
          // LOCKED: held until clear
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
      idx_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= BLANK_CHAR;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

endmodule
